// File: rtl/xalu_ctrl_if.sv
// Stage-E to multiply/divide sequencer bundle: request operands in, status and HI/LO out.
interface xalu_ctrl_if;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (output op, a, b, input busy, done, hi, lo, rd_data);
  modport slave  (input op, a, b, output busy, done, hi, lo, rd_data);
endinterface

// File: rtl/xalu_ctrl.sv
// Multi-cycle mult/div sequencer with HI/LO registers; busy holds for a fixed latency per op class.
module xalu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic         clk,
  input logic         reset,
  xalu_ctrl_if.slave  bus
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          done_q, done_d;

  logic [31:0] res_hi, res_lo;
  logic        res_wr;
  logic        sgn;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, div_by, q_mag, r_mag;

  // Result uses only latched operands; signed division works on magnitudes so
  // 0x80000000 / -1 falls out naturally without an overflowing signed divide.
  always_comb begin
    sgn    = (op_q == 4'd1) || (op_q == 4'd3);
    prod   = {{32{sgn & a_q[31]}}, a_q} * {{32{sgn & b_q[31]}}, b_q};
    a_mag  = (sgn && a_q[31]) ? (32'd0 - a_q) : a_q;
    b_mag  = (sgn && b_q[31]) ? (32'd0 - b_q) : b_q;
    div_by = (b_mag == '0) ? 32'd1 : b_mag;
    q_mag  = a_mag / div_by;
    r_mag  = a_mag % div_by;
    res_wr = 1'b1;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if ((op_q == 4'd3) || (op_q == 4'd4)) begin
      res_wr = (b_q != '0);
      res_lo = (sgn && (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
      res_hi = (sgn && a_q[31]) ? (32'd0 - r_mag) : r_mag;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        case (bus.op)
          4'd1, 4'd2, 4'd3, 4'd4: begin
            op_d    = bus.op;
            a_d     = bus.a;
            b_d     = bus.b;
            cnt_d   = (bus.op <= 4'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state_d = RUN;
          end
          4'd5:    hi_d = bus.a;
          4'd6:    lo_d = bus.a;
          default: ;
        endcase
      end
      RUN: begin
        if (cnt_q > CW'(1)) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (res_wr) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = done_q;
    bus.hi   = hi_q;
    bus.lo   = lo_q;
    case (bus.op)
      4'd7:    bus.rd_data = hi_q;
      4'd8:    bus.rd_data = lo_q;
      default: bus.rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_xalu_ctrl.sv
// Self-checking bench for xalu_ctrl: directed plan steps then random ops against a behavioural model.
module tb_xalu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk;
  logic reset;
  xalu_ctrl_if xif ();

  xalu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (xif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int busy_seen = 0;
  int done_seen = 0;
  logic [31:0] rd_seen;

  // Reference state: architectural HI/LO, cycles left in flight and the pending result.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        p_wr, m_done;
  int          m_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                            input bit rst_n);
    logic [63:0] p;
    longint sa, sb, q, r;
    logic [63:0] qb, rb;
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          if (p_wr) begin m_hi = p_hi; m_lo = p_lo; end
        end
      end else begin
        case (o)
          4'd1: begin
            sa = longint'($signed(aa)); sb = longint'($signed(bb));
            p = sa * sb; p_hi = p[63:32]; p_lo = p[31:0]; p_wr = 1'b1; m_left = MC;
          end
          4'd2: begin
            p = {32'd0, aa} * {32'd0, bb}; p_hi = p[63:32]; p_lo = p[31:0]; p_wr = 1'b1; m_left = MC;
          end
          4'd3: begin
            m_left = DC; p_wr = (bb != 0);
            if (p_wr) begin
              sa = longint'($signed(aa)); sb = longint'($signed(bb));
              q = sa / sb; r = sa % sb; qb = q; rb = r;
              p_lo = qb[31:0]; p_hi = rb[31:0];
            end
          end
          4'd4: begin
            m_left = DC; p_wr = (bb != 0);
            if (p_wr) begin p_lo = aa / bb; p_hi = aa % bb; end
          end
          4'd5: m_hi = aa;
          4'd6: m_lo = aa;
          default: ;
        endcase
      end
    end
  endtask

  task automatic cycle(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input bit rst_n);
    xif.op = o; xif.a = aa; xif.b = bb; reset = rst_n;
    #1;
    rd_seen = xif.rd_data;
    chk("rd_data", xif.rd_data, (o == 4'd7) ? m_hi : (o == 4'd8) ? m_lo : 32'd0);
    @(posedge clk);
    model_edge(o, aa, bb, rst_n);
    #1;
    if (xif.busy === 1'b1) busy_seen++;
    if (xif.done === 1'b1) done_seen++;
    chk("busy", {31'd0, xif.busy}, {31'd0, m_left > 0});
    chk("done", {31'd0, xif.done}, {31'd0, m_done});
    chk("hi", xif.hi, m_hi);
    chk("lo", xif.lo, m_lo);
  endtask

  task automatic idle(input int n, input logic [31:0] aa = 32'd0, input logic [31:0] bb = 32'd0);
    for (int i = 0; i < n; i++) cycle(4'd0, aa, bb, 1'b1);
  endtask

  task automatic clr_seen();
    busy_seen = 0; done_seen = 0;
  endtask

  initial begin
    logic [3:0] ro;
    logic [31:0] ra, rb;
    bit rr;
    m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_wr = 1'b0; m_done = 1'b0; m_left = 0;
    xif.op = '0; xif.a = '0; xif.b = '0; reset = 1'b0;

    cycle(4'd0, 32'd0, 32'd0, 1'b0);
    cycle(4'd0, 32'd0, 32'd0, 1'b0);
    chk("rst_hi", xif.hi, 32'd0);
    chk("rst_busy", {31'd0, xif.busy}, 32'd0);

    clr_seen();
    cycle(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1);
    idle(MC + 1);
    chk("mult_busy_cycles", busy_seen, MC);
    chk("mult_done_pulses", done_seen, 1);
    chk("mult_hi", xif.hi, 32'hFFFFFFFF);
    chk("mult_lo", xif.lo, 32'hFFFFFFFA);

    cycle(4'd2, 32'hFFFFFFFF, 32'd2, 1'b1);
    idle(MC + 1, 32'd0, 32'd0);
    chk("multu_hi", xif.hi, 32'h00000001);
    chk("multu_lo", xif.lo, 32'hFFFFFFFE);

    clr_seen();
    cycle(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    idle(DC + 1);
    chk("div_busy_cycles", busy_seen, DC);
    chk("div_lo", xif.lo, 32'hFFFFFFFD);
    chk("div_hi", xif.hi, 32'hFFFFFFFF);

    clr_seen();
    cycle(4'd4, 32'd7, 32'd0, 1'b1);
    idle(DC + 1);
    chk("divu0_busy_cycles", busy_seen, DC);
    chk("divu0_done_pulses", done_seen, 1);
    chk("divu0_lo", xif.lo, 32'hFFFFFFFD);
    chk("divu0_hi", xif.hi, 32'hFFFFFFFF);

    clr_seen();
    cycle(4'd5, 32'h12345678, 32'd0, 1'b1);
    cycle(4'd7, 32'd0, 32'd0, 1'b1);
    chk("mfhi_rd", rd_seen, 32'h12345678);
    cycle(4'd6, 32'hCAFEBABE, 32'd0, 1'b1);
    cycle(4'd8, 32'd0, 32'd0, 1'b1);
    chk("mflo_rd", rd_seen, 32'hCAFEBABE);
    chk("mtx_busy_cycles", busy_seen, 0);

    cycle(4'd1, 32'd7, 32'd6, 1'b1);
    cycle(4'd0, 32'd0, 32'd0, 1'b1);
    cycle(4'd5, 32'h0000DEAD, 32'd0, 1'b1);
    idle(MC);
    chk("mthi_in_run_hi", xif.hi, 32'd0);
    chk("mthi_in_run_lo", xif.lo, 32'd42);

    cycle(4'd3, 32'd100, 32'd7, 1'b1);
    idle(3);
    clr_seen();
    cycle(4'd0, 32'd0, 32'd0, 1'b0);
    chk("abort_busy", {31'd0, xif.busy}, 32'd0);
    chk("abort_hi", xif.hi, 32'd0);
    chk("abort_lo", xif.lo, 32'd0);
    idle(DC + 2);
    chk("abort_done_pulses", done_seen, 0);

    cycle(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    idle(DC + 1);
    chk("divovf_lo", xif.lo, 32'h80000000);
    chk("divovf_hi", xif.hi, 32'd0);

    clr_seen();
    cycle(4'd1, 32'd3, 32'd5, 1'b1);
    idle(MC - 1);
    cycle(4'd3, 32'd9, 32'd2, 1'b1);
    idle(DC + 2);
    chk("late_start_lo", xif.lo, 32'd15);
    chk("late_start_done_pulses", done_seen, 1);

    for (int i = 0; i < 400; i++) begin
      ro = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) ro = 4'($urandom_range(1, 8));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 9) == 0) rb = 32'd0;
      if ($urandom_range(0, 4) == 0) rb = 32'($urandom_range(1, 9)) ^ {32{rb[31]}};
      rr = ($urandom_range(0, 63) != 0);
      cycle(ro, ra, rb, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
